tile_fetch_arb: RTL

// - Schedules the shared single-port video RAM between the tile renderer and the CPU.
// - Once per 8-pixel tile slot, prefetches the next tile's code (TILE_BASE+offset) and palette

---
 rtl/tile_fetch_arb.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/tile_fetch_arb.sv
// Shared video-RAM scheduler: one tile-code/palette prefetch per 8-pixel slot, CPU gets the rest.
// Optional build macro VRAM_RANGE_CHECK_EN short-circuits CPU accesses outside the VRAM window.
module tile_fetch_arb #(
    parameter logic [15:0] TILE_BASE = 16'h4000,
    parameter logic [15:0] PAL_BASE  = 16'h4400,
    parameter logic [8:0]  ROW_MAX   = 9'd288,
    parameter logic [9:0]  COL_MAX   = 10'd224
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_tick,
    input  logic [8:0]  i_row,
    input  logic [9:0]  i_col,
    input  logic        i_blank,
    input  logic [15:0] i_vid_offset,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [7:0]  o_mem_wdata,
    input  logic [7:0]  i_mem_rdata,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    output logic        o_cpu_ack,
    output logic [7:0]  o_cpu_rdata,
    output logic [7:0]  o_tile_code,
    output logic [5:0]  o_palette_code,
    output logic        o_tile_valid,
    output logic        o_fetch_miss
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_V_TILE,
        S_V_PAL,
        S_V_DONE,
        S_C_ADDR,
        S_C_DATA
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_pend;
    logic [AW-1:0]  r_vid_q;
    logic [DW-1:0]  r_tile_shadow;
    logic [PW-1:0]  r_pal_shadow;
    logic           r_shadow_full;
    logic [DW-1:0]  r_tile_code;
    logic [PW-1:0]  r_palette_code;
    logic           r_tile_valid;
    logic           r_fetch_miss;

    logic           w_slot_start;
    logic           w_miss;
    logic           w_video_due;
    logic           w_cpu_oor;
    logic [AW-1:0]  w_mem_addr;
    logic           w_mem_we;
    logic [DW-1:0]  w_mem_wdata;
    logic           w_cpu_ack;
    logic [DW-1:0]  w_cpu_rdata;

    assign w_slot_start = i_pix_tick & (i_col[2:0] == 3'd0) & (i_row < ROW_MAX)
                        & (i_col < COL_MAX) & ~i_blank;
    assign w_miss       = w_slot_start & r_pend;
    assign w_video_due  = r_pend | w_slot_start;

`ifdef VRAM_RANGE_CHECK_EN
    localparam logic [AW-1:0] VRAM_END = AW'(PAL_BASE + 16'h03FF);
    assign w_cpu_oor = (i_cpu_addr < TILE_BASE) | (i_cpu_addr > VRAM_END);
`else
    assign w_cpu_oor = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and the combinational RAM/CPU port drive
    always_comb begin
        w_state_nxt = r_state;
        w_mem_addr  = '0;
        w_mem_we    = 1'b0;
        w_mem_wdata = '0;
        w_cpu_ack   = 1'b0;
        w_cpu_rdata = '0;
        case (r_state)
            S_IDLE: begin
                if (w_video_due) begin
                    w_state_nxt = S_V_TILE;
                end else if (i_cpu_req) begin
                    w_state_nxt = w_cpu_oor ? S_C_DATA : S_C_ADDR;
                end
            end
            S_V_TILE: begin
                w_mem_addr  = AW'(TILE_BASE + r_vid_q);
                // A second slot start abandons this fetch; IDLE restarts it with the new offset.
                w_state_nxt = w_miss ? S_IDLE : S_V_PAL;
            end
            S_V_PAL: begin
                w_mem_addr  = AW'(PAL_BASE + r_vid_q);
                w_state_nxt = w_miss ? S_IDLE : S_V_DONE;
            end
            S_V_DONE: begin
                w_state_nxt = S_IDLE;
            end
            S_C_ADDR: begin
                w_mem_addr  = i_cpu_addr;
                w_mem_we    = i_cpu_we;
                w_mem_wdata = i_cpu_wdata;
                w_state_nxt = S_C_DATA;
            end
            S_C_DATA: begin
                w_mem_addr  = i_cpu_addr;
                w_cpu_ack   = 1'b1;
                w_cpu_rdata = w_cpu_oor ? 8'hFF : i_mem_rdata;
                // A video fetch held off by this CPU op starts in the slot IDLE would take.
                w_state_nxt = w_video_due ? S_V_TILE : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Slot bookkeeping, shadow capture and tile commit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend         <= 1'b0;
            r_vid_q        <= '0;
            r_tile_shadow  <= '0;
            r_pal_shadow   <= '0;
            r_shadow_full  <= 1'b0;
            r_tile_code    <= '0;
            r_palette_code <= '0;
            r_tile_valid   <= 1'b0;
            r_fetch_miss   <= 1'b0;
        end else begin
            r_fetch_miss <= w_miss;
            if (w_slot_start) begin
                r_vid_q        <= i_vid_offset;
                r_pend         <= 1'b1;
                r_tile_code    <= r_tile_shadow;
                r_palette_code <= r_pal_shadow;
                r_tile_valid   <= r_shadow_full;
                r_shadow_full  <= 1'b0;
            end else begin
                if (r_state == S_V_DONE) begin
                    r_pend        <= 1'b0;
                    r_shadow_full <= 1'b1;
                end
                if (i_blank) begin
                    r_tile_valid <= 1'b0;
                end
            end
            // RAM data lags the address by one cycle
            if (r_state == S_V_PAL) begin
                r_tile_shadow <= i_mem_rdata;
            end
            if (r_state == S_V_DONE) begin
                r_pal_shadow <= i_mem_rdata[PW-1:0];
            end
        end
    end

    assign o_mem_addr     = w_mem_addr;
    assign o_mem_we       = w_mem_we;
    assign o_mem_wdata    = w_mem_wdata;
    assign o_cpu_ack      = w_cpu_ack;
    assign o_cpu_rdata    = w_cpu_rdata;
    assign o_tile_code    = r_tile_code;
    assign o_palette_code = r_palette_code;
    assign o_tile_valid   = r_tile_valid;
    assign o_fetch_miss   = r_fetch_miss;

endmodule
